// File: rtl/nios_mult_seq_pkg.sv
// Shared types for the sequential Nios multiplier: op/state encodings and PP iteration count.
// Latency: n/a (types only). Backpressure: n/a.
// NIOS_MULT_SEQ_MULL_SHORTCUT_EN trims MUL to the low-half partial products.
package nios_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PP,
    ST_CORR,
    ST_DONE
  } state_e;

`ifdef NIOS_MULT_SEQ_MULL_SHORTCUT_EN
  localparam bit SHORTCUT_EN = 1'b1;
`else
  localparam bit SHORTCUT_EN = 1'b0;
`endif

  // MUL only needs products landing in the low half (i+j < n) when the shortcut is on.
  function automatic int unsigned pp_count(op_e op, int unsigned n);
    return (SHORTCUT_EN && op == OP_MUL) ? (n * (n + 1)) / 2 : n * n;
  endfunction

endpackage

// File: rtl/nios_mult_seq_if.sv
// Operand/result valid-ready bundle between the M stage and the sequential multiplier.
// Latency: n/a (wiring only). Backpressure: out_ready stalls results, in_ready gates requests.
// No configuration macros.
interface nios_mult_seq_if
  import nios_mult_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/nios_mult_seq_slice_mac.sv
// One SLICE x SLICE unsigned partial product, shifted by SLICE*k and added to the accumulator.
// Latency: combinational. Backpressure: none.
// No configuration macros.
module nios_mult_slice_mac #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16,
  parameter int KW    = 2
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [SLICE-1:0]   a_sl,
  input  logic [SLICE-1:0]   b_sl,
  input  logic [KW-1:0]      k,
  output logic [2*WIDTH-1:0] acc_out
);
  localparam int AW = 2 * WIDTH;

  logic [2*SLICE-1:0] prod;
  logic [AW-1:0]      prod_sh;

  assign prod    = a_sl * b_sl;
  assign prod_sh = AW'(prod) << (k * SLICE);
  assign acc_out = acc_in + prod_sh;
endmodule

// File: rtl/nios_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier (MUL/MULXUU/MULXSU/MULXSS) iterating one SLICE multiplier.
// Latency: N*N+1 cycles unsigned, N*N+2 signed; MUL N(N+1)/2+1 with NIOS_MULT_SEQ_MULL_SHORTCUT_EN.
// Backpressure: result held in DONE until out_ready; in_ready low from accept to return to IDLE.
module nios_mult_seq
  import nios_mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  nios_mult_seq_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N * N + 1);
  localparam int AW = 2 * WIDTH;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [AW-1:0]    acc_q;
  logic [IW-1:0]    i_q, j_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;

  logic [N-1:0][SLICE-1:0] a_sl, b_sl;
  logic [IW:0]             k;
  logic [AW-1:0]           mac_out;
  logic                    last_pp;
  logic                    signed_op;
  logic                    short_mul;
  logic [IW-1:0]           j_lim;
  logic [WIDTH-1:0]        sub_a, sub_b, corr_hi;
  logic [WIDTH-1:0]        pp_result;

  assign a_sl = a_q;
  assign b_sl = b_q;
  assign k    = {1'b0, i_q} + {1'b0, j_q};

  nios_mult_slice_mac #(
    .WIDTH (WIDTH),
    .SLICE (SLICE),
    .KW    (IW + 1)
  ) u_mac (
    .acc_in  (acc_q),
    .a_sl    (a_sl[i_q]),
    .b_sl    (b_sl[j_q]),
    .k       (k),
    .acc_out (mac_out)
  );

  assign signed_op = (op_q == OP_MULXSU) || (op_q == OP_MULXSS);
  assign short_mul = SHORTCUT_EN && (op_q == OP_MUL);
  assign last_pp   = (cnt_q == CW'(pp_count(op_q, N) - 1));
  // Under the shortcut, row i stops at the last j that still lands in the low half.
  assign j_lim     = short_mul ? IW'(N - 1) - i_q : IW'(N - 1);

  // Two's-complement fix-up of the unsigned product: a negative operand contributes
  // an extra -(other << WIDTH), which only touches the high half.
  assign sub_b     = (signed_op && a_q[WIDTH-1])            ? b_q : '0;
  assign sub_a     = ((op_q == OP_MULXSS) && b_q[WIDTH-1]) ? a_q : '0;
  assign corr_hi   = acc_q[AW-1:WIDTH] - sub_b - sub_a;

  assign pp_result = (op_q == OP_MUL) ? mac_out[WIDTH-1:0] : mac_out[AW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            op_q       <= bus.in_op;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_PP;
          end
        end
        ST_PP: begin
          acc_q <= mac_out;
          cnt_q <= cnt_q + 1'b1;
          if (j_q == j_lim) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
          if (last_pp) begin
            if (signed_op) begin
              state_q <= ST_CORR;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= pp_result;
            end
          end
        end
        ST_CORR: begin
          acc_q       <= {corr_hi, acc_q[WIDTH-1:0]};
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
          result_q    <= corr_hi;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
endmodule

// File: tb/tb_nios_mult_seq.sv
// Directed plus random bench for nios_mult_seq (32/16), checked against a plain 64-bit arithmetic model.
// Honours NIOS_MULT_SEQ_MULL_SHORTCUT_EN for the expected MUL latency.
module tb_nios_mult_seq;
  import nios_mult_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  nios_mult_seq_if #(.WIDTH(32)) bus ();

  nios_mult_seq #(
    .WIDTH (32),
    .SLICE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(op_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      OP_MULXSU: p = sa * ub;
      OP_MULXSS: p = sa * sb;
      default:   p = ua * ub;
    endcase
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(op_e op);
`ifdef NIOS_MULT_SEQ_MULL_SHORTCUT_EN
    if (op == OP_MUL) return 4;
`endif
    return (op == OP_MULXSU || op == OP_MULXSS) ? 6 : 5;
  endfunction

  // Entered at a negedge with the block idle; leaves at a negedge with the block idle again.
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    logic [31:0] first;
    int          lat;
    exp = ref_mul(op, a, b);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    // Junk requests while busy must be ignored.
    bus.in_a  = $urandom;
    bus.in_b  = $urandom;
    bus.in_op = op_e'(2'($urandom_range(3, 0)));
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    end
    check("latency", 32'(lat), 32'(exp_lat(op)));
    check("result", bus.out_result, exp);
    first = bus.out_result;
    repeat (hold) begin
      @(negedge clk);
      check("hold_result", bus.out_result, first);
      check("hold_flags", 32'({bus.in_ready, bus.out_valid}), 32'b01);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("idle_after", 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  // kind 0: flush sampled at cycle 2; kind 1: reset sampled at cycle 3.
  task automatic abort_op(input int kind);
    logic seen_valid;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MULXSS;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat ((kind == 0) ? 2 : 3) @(negedge clk);
    if (kind == 0) flush = 1'b1;
    else           reset = 1'b1;
    seen_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    reset = 1'b0;
    check(kind == 0 ? "flush_ready" : "reset_ready", 32'(bus.in_ready), 32'd1);
    if (kind == 1) check("reset_result", bus.out_result, 32'd0);
    repeat (8) begin
      if (bus.out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check(kind == 0 ? "flush_no_valid" : "reset_no_valid", 32'(seen_valid), 32'd0);
    run_op(OP_MUL, 32'd3, 32'd5, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);

    run_op(OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MUL,    32'h0001_0003, 32'h0002_0005, 0);
    run_op(OP_MULXUU, 32'h0001_0003, 32'h0002_0005, 0);
    run_op(OP_MULXSS, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(OP_MUL,    32'hDEAD_BEEF, 32'h1234_5678, 3);
    run_op(OP_MULXSU, 32'h8000_0001, 32'h7FFF_FFFF, 3);

    abort_op(0);
    abort_op(1);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(5, 0))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h0000_FFFF;
        default: ;
      endcase
      run_op(op_e'(2'(n % 4)), ra, rb, $urandom_range(2, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
